vga_scan_out: RTL and testbench

- Read side of the pixel FIFO that display_pane fills with 8x-upscaled 640x480 pixels.
- Runs in the pixel-clock domain and generates 640x480@60 VGA timing.
- Pops one FIFO word per active pixel and drives registered RGB, sync and blank outputs to the DAC or connector.
- Handles start-up alignment and FIFO underflow deterministically.

---
 rtl/vga_scan_out.sv | 112 +++++++++++
 tb/tb_vga_scan_out.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_out.sv
// rtl/vga_scan_out.sv - pixel-clock VGA timing generator draining the upscaled pixel FIFO
module vga_scan_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] data_in,
    input  logic        empty,
    output logic        read_en,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start,
    output logic        underflow
);

    localparam logic [9:0] H_ACT_W    = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT_W    = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic {
        S_WAIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       active;

    // Visible pixel region of the raster, from the current counter position
    always_comb begin
        active  = (h_cnt < H_ACT_W) && (v_cnt < V_ACT_W);
        read_en = (state == S_RUN) && active && !empty;
    end

    // Start-up FSM, raster counters and the one-cycle-latency output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_WAIT;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    // Hold the raster at (0,0) until the writer has produced the first pixel
                    if (!empty) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Timing free-runs regardless of FIFO level so sync cadence never drifts
                    if (h_cnt == H_LAST) begin
                        h_cnt <= '0;
                        if (v_cnt == V_LAST) begin
                            v_cnt <= '0;
                        end else begin
                            v_cnt <= v_cnt + 10'd1;
                        end
                    end else begin
                        h_cnt <= h_cnt + 10'd1;
                    end

                    hsync       <= !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
                    vsync       <= !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
                    blank_n     <= active;
                    frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);

                    if (active && !empty) begin
                        red   <= data_in[23:16];
                        green <= data_in[15:8];
                        blue  <= data_in[7:0];
                    end else begin
                        // Blanking and starved pixels both go out black; starved ones are not replayed
                        red   <= '0;
                        green <= '0;
                        blue  <= '0;
                    end

                    if (active && empty) begin
                        underflow <= 1'b1;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_scan_out.sv
// tb/tb_vga_scan_out.sv - scoreboard bench for vga_scan_out on a shrunken raster
module tb_vga_scan_out;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
        logic        uf;
        logic [23:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] data_in = '0;
    logic        empty = 1'b0;
    logic        read_en;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        frame_start;
    logic        underflow;

    int total = 0;
    int bad = 0;

    exp_t q[$];
    bit          m_run;
    int          mh;
    int          mv;
    bit          m_uf;
    logic [23:0] next_val;

    int          cyc;
    int          pops;
    int          last_fs;
    int          bl_rise;
    int          hs_fall;
    int          vs_fall;
    bit          prev_bl;
    bit          prev_hs;
    bit          prev_vs;
    bit          chk_pops;
    bit          chk_order;
    bit          have_last;
    logic [23:0] last_rgb;

    vga_scan_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .empty(empty),
        .read_en(read_en),
        .hsync(hsync),
        .vsync(vsync),
        .blank_n(blank_n),
        .red(red),
        .green(green),
        .blue(blue),
        .frame_start(frame_start),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run     = 1'b0;
        mh        = 0;
        mv        = 0;
        m_uf      = 1'b0;
        cyc       = 0;
        pops      = 0;
        last_fs   = -1;
        bl_rise   = -1;
        hs_fall   = -1;
        vs_fall   = -1;
        prev_bl   = 1'b0;
        prev_hs   = 1'b1;
        prev_vs   = 1'b1;
        have_last = 1'b0;
        q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_outs"}, {hsync, vsync, blank_n, red, green, blue, frame_start, underflow},
              {1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0});
        check({tag, "_read_en"}, read_en, 1'b0);
    endtask

    // One pixel clock: drive inputs at negedge, predict, clock, compare at next negedge
    task automatic cycle(input bit e);
        exp_t ex;
        exp_t ob;
        bit   act;
        bit   ere;
        empty   = e;
        data_in = next_val;
        #1;
        act = m_run && (mh < HA) && (mv < VA);
        ere = act && !e;
        check("read_en", read_en, ere);
        ex = '0;
        if (!m_run) begin
            ex.hs = 1'b1;
            ex.vs = 1'b1;
            if (!e) m_run = 1'b1;
        end else begin
            ex.hs  = !((mh >= HA + HF) && (mh < HA + HF + HS));
            ex.vs  = !((mv >= VA + VF) && (mv < VA + VF + VS));
            ex.bl  = act;
            ex.fs  = (mh == 0) && (mv == 0);
            if (act && e) m_uf = 1'b1;
            ex.rgb = ere ? next_val : 24'h0;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        ex.uf = m_uf;
        q.push_back(ex);
        if (ere) begin
            pops++;
            next_val = next_val + 24'd1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        ob.hs  = hsync;
        ob.vs  = vsync;
        ob.bl  = blank_n;
        ob.fs  = frame_start;
        ob.uf  = underflow;
        ob.rgb = {red, green, blue};
        ex = q.pop_front();
        check("outputs", ob, ex);

        if (frame_start) begin
            if (last_fs >= 0) begin
                check("frame_period", cyc - last_fs, FR);
                if (chk_pops) check("pops_per_frame", pops - 1, HA * VA);
            end
            pops    = 1;
            last_fs = cyc;
        end
        if (blank_n && !prev_bl) bl_rise = cyc;
        if (!blank_n && prev_bl) check("blank_len", cyc - bl_rise, HA);
        if (!hsync && prev_hs) begin
            if (hs_fall >= 0) check("line_period", cyc - hs_fall, HT);
            if (bl_rise >= 0 && cyc - bl_rise < HT) check("hsync_offset", cyc - bl_rise, HA + HF);
            hs_fall = cyc;
        end
        if (hsync && !prev_hs) check("hsync_len", cyc - hs_fall, HS);
        if (!vsync && prev_vs) begin
            if (last_fs >= 0) check("vsync_start", cyc - last_fs, (VA + VF) * HT);
            vs_fall = cyc;
        end
        if (vsync && !prev_vs) check("vsync_len", cyc - vs_fall, VS * HT);
        if (blank_n && chk_order) begin
            if (have_last) check("order", {red, green, blue}, last_rgb + 24'd1);
            last_rgb  = {red, green, blue};
            have_last = 1'b1;
        end
        prev_bl = blank_n;
        prev_hs = hsync;
        prev_vs = vsync;
    endtask

    initial begin
        int n;
        model_reset();
        next_val  = 24'hAABBCC;
        chk_pops  = 1'b1;
        chk_order = 1'b1;

        // Reset held with data available
        rst   = 1'b1;
        empty = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_hold");

        // Release with FIFO empty: must stay idle
        rst   = 1'b0;
        empty = 1'b1;
        repeat (20) cycle(1'b1);

        // Start-up and first pixel
        cycle(1'b0);
        cycle(1'b0);
        check("first_pixel", {red, green, blue, blank_n, frame_start}, {24'hAABBCC, 1'b1, 1'b1});
        cycle(1'b0);
        check("frame_start_width", frame_start, 1'b0);

        // Two-plus frames of line/frame timing with an always-full FIFO
        repeat (2 * FR + 5) cycle(1'b0);

        // Advance to line 2, pixel 3, then starve the FIFO for 5 pixels
        n = 0;
        while (!(mv == 2 && mh == 3) && n < 2 * FR) begin
            cycle(1'b0);
            n++;
        end
        check("reach_underflow_point", {mv[7:0], mh[7:0]}, {8'd2, 8'd3});
        chk_pops  = 1'b0;
        chk_order = 1'b0;
        repeat (5) cycle(1'b1);
        check("underflow_set", underflow, 1'b1);
        repeat (FR + 10) cycle(1'b0);
        check("underflow_sticky", underflow, 1'b1);

        // Mid-line asynchronous reset
        n = 0;
        while (!(mv < VA && mh == 5) && n < 2 * FR) begin
            cycle(1'b0);
            n++;
        end
        check("reach_reset_point", mh, 5);
        empty = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        repeat (5) cycle(1'b1);
        check("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
